// File: rtl/q1_pkg.sv
// Shared encodings for the q1 five-state Moore machine.
// State codes are fixed so that benches can probe the register by value.
package q1_pkg;

  typedef enum logic [2:0] {
    S_A = 3'b000,
    S_B = 3'b001,
    S_C = 3'b010,
    S_D = 3'b011,
    S_E = 3'b100
  } state_t;

  localparam logic [1:0] IN_00 = 2'b00;
  localparam logic [1:0] IN_01 = 2'b01;
  localparam logic [1:0] IN_10 = 2'b10;
  localparam logic [1:0] IN_11 = 2'b11;

endpackage

// File: rtl/q1_fsm.sv
// Five-state Moore FSM (A..E) stepped by a 2-bit code; out flags residence in E.
// Synchronous active-high reset returns to A; unused state codes recover to A.
module q1_fsm
  import q1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  output logic       out
);

  state_t present_state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      present_state <= S_A;
    end else begin
      present_state <= next_state;
    end
  end

  // Unmatched input codes (including X/Z) fall through to the hold default.
  always_comb begin
    next_state = present_state;
    case (present_state)
      S_A: begin
        case (in)
          IN_01:   next_state = S_B;
          IN_10:   next_state = S_D;
          IN_11:   next_state = S_A;
          IN_00:   next_state = S_A;
          default: next_state = present_state;
        endcase
      end
      S_B: begin
        case (in)
          IN_00:   next_state = S_A;
          default: next_state = present_state;
        endcase
      end
      S_C: begin
        case (in)
          IN_01:   next_state = S_E;
          IN_11:   next_state = S_B;
          default: next_state = present_state;
        endcase
      end
      S_D: begin
        case (in)
          IN_00:   next_state = S_C;
          default: next_state = present_state;
        endcase
      end
      S_E: begin
        case (in)
          IN_11:   next_state = S_D;
          default: next_state = present_state;
        endcase
      end
      default: next_state = S_A;
    endcase
  end

  assign out = (present_state == S_E);

endmodule

// File: tb/tb_q1_fsm.sv
// Directed bench for q1_fsm: reset, main path, hold cases, mid-sequence reset,
// and recovery from an illegal state code.
module tb_q1_fsm;
  import q1_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] in;
  logic       out;

  int checks;
  int errors;

  q1_fsm dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_state(input string tag, input logic [2:0] exp_state, input logic exp_out);
    checks++;
    assert (dut.present_state === exp_state) else begin
      errors++;
      $error("FAIL %s state: observed %b expected %b", tag, dut.present_state, exp_state);
    end
    checks++;
    assert (out === exp_out) else begin
      errors++;
      $error("FAIL %s out: observed %b expected %b", tag, out, exp_out);
    end
  endtask

  // Drive inputs away from the edge, clock once, then sample just after the edge.
  task automatic step(input string tag, input logic rst, input logic [1:0] code,
                      input logic [2:0] exp_state, input logic exp_out);
    @(negedge clk);
    reset = rst;
    in    = code;
    @(posedge clk);
    #1;
    check_state(tag, exp_state, exp_out);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    in     = 2'b00;

    // Reset, including reset overriding a live code.
    step("reset_hold",    1'b1, 2'b01, 3'b000, 1'b0);
    step("reset_release", 1'b0, 2'b00, 3'b000, 1'b0);

    // Main path.
    step("main_01_B",  1'b0, 2'b01, 3'b001, 1'b0);
    step("main_00_A",  1'b0, 2'b00, 3'b000, 1'b0);
    step("main_10_D",  1'b0, 2'b10, 3'b011, 1'b0);
    step("main_00_C",  1'b0, 2'b00, 3'b010, 1'b0);
    step("main_00_C2", 1'b0, 2'b00, 3'b010, 1'b0);
    step("main_11_B",  1'b0, 2'b11, 3'b001, 1'b0);
    step("main_00_A2", 1'b0, 2'b00, 3'b000, 1'b0);
    step("main_10_D2", 1'b0, 2'b10, 3'b011, 1'b0);
    step("main_00_C3", 1'b0, 2'b00, 3'b010, 1'b0);
    step("main_01_E",  1'b0, 2'b01, 3'b100, 1'b1);
    step("main_00_E",  1'b0, 2'b00, 3'b100, 1'b1);
    step("main_11_D",  1'b0, 2'b11, 3'b011, 1'b0);

    // Hold cases: D on 01, E on 10, B on 11, A on 00.
    step("hold_D_01",  1'b0, 2'b01, 3'b011, 1'b0);
    step("to_C",       1'b0, 2'b00, 3'b010, 1'b0);
    step("to_E",       1'b0, 2'b01, 3'b100, 1'b1);
    step("hold_E_10",  1'b0, 2'b10, 3'b100, 1'b1);
    step("hold_E_01",  1'b0, 2'b01, 3'b100, 1'b1);
    step("E_11_D",     1'b0, 2'b11, 3'b011, 1'b0);
    step("D_00_C",     1'b0, 2'b00, 3'b010, 1'b0);
    step("hold_C_10",  1'b0, 2'b10, 3'b010, 1'b0);
    step("C_11_B",     1'b0, 2'b11, 3'b001, 1'b0);
    step("hold_B_11",  1'b0, 2'b11, 3'b001, 1'b0);
    step("hold_B_01",  1'b0, 2'b01, 3'b001, 1'b0);
    step("B_00_A",     1'b0, 2'b00, 3'b000, 1'b0);
    step("hold_A_00",  1'b0, 2'b00, 3'b000, 1'b0);
    step("A_11_A",     1'b0, 2'b11, 3'b000, 1'b0);

    // Mid-sequence reset from E with in=11 must land in A, not D.
    step("mid_A_10_D", 1'b0, 2'b10, 3'b011, 1'b0);
    step("mid_D_00_C", 1'b0, 2'b00, 3'b010, 1'b0);
    step("mid_C_01_E", 1'b0, 2'b01, 3'b100, 1'b1);
    step("mid_reset",  1'b1, 2'b11, 3'b000, 1'b0);
    step("post_reset", 1'b0, 2'b00, 3'b000, 1'b0);

    // Illegal state code recovers to A on the next edge.
    @(negedge clk);
    reset = 1'b0;
    in    = 2'b11;
    force dut.present_state = state_t'(3'b110);
    #1;
    check_state("illegal_forced", 3'b110, 1'b0);
    release dut.present_state;
    @(posedge clk);
    #1;
    check_state("illegal_recover", 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
